// File: rtl/ifetch_mem_responder_if.sv
// rtl/ifetch_mem_responder_if.sv - fetch-side and SRAM-side signal bundle for ifetch_mem_responder
//
// Purpose: groups the fetch request/response handshake, the flush strobe and
// the instruction SRAM read port into one bundle.
//   slave  modport: the responder (ifetch_mem_responder)
//   master modport: the fetch stage plus the SRAM model driving it
// Signals:
//   req_valid/req_ready/req_addr     fetch request handshake, 64-bit byte address
//   flush                            discard in-flight request (branch redirect)
//   resp_valid/resp_ready            response handshake
//   resp_pc/resp_inst/resp_fault     returned pc, instruction word, access fault
//   mem_en/mem_addr/mem_rdata        synchronous-read SRAM port, data one cycle after mem_en

interface ifetch_mem_responder_if #(
    parameter int PMEM_AW = 16
);
    logic               req_valid;
    logic               req_ready;
    logic [63:0]        req_addr;
    logic               flush;
    logic               resp_valid;
    logic               resp_ready;
    logic [63:0]        resp_pc;
    logic [31:0]        resp_inst;
    logic               resp_fault;
    logic               mem_en;
    logic [PMEM_AW-1:0] mem_addr;
    logic [31:0]        mem_rdata;

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_addr,
        input  flush,
        output resp_valid,
        input  resp_ready,
        output resp_pc,
        output resp_inst,
        output resp_fault,
        output mem_en,
        output mem_addr,
        input  mem_rdata
    );

    modport master (
        output req_valid,
        input  req_ready,
        output req_addr,
        output flush,
        input  resp_valid,
        output resp_ready,
        input  resp_pc,
        input  resp_inst,
        input  resp_fault,
        input  mem_en,
        input  mem_addr,
        output mem_rdata
    );
endinterface

// File: rtl/ifetch_mem_responder.sv
// rtl/ifetch_mem_responder.sv - instruction-fetch responder over a word-wide synchronous SRAM with RVC support
//
// Purpose: accepts a halfword-aligned fetch address, reads the instruction
// SRAM (one word, or two when a 32-bit instruction straddles a word
// boundary) and returns a 32-bit instruction word with its pc. Odd or
// out-of-range addresses return an access fault without touching the SRAM.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    ifetch_mem_responder_if.slave: fetch request/response handshake,
//          flush, and the SRAM read port (mem_en/mem_addr combinational)
// Parameters:
//   PMEM_BASE  byte address of SRAM word 0
//   PMEM_AW    SRAM word-address width (2^PMEM_AW words)

module ifetch_mem_responder #(
    parameter logic [63:0] PMEM_BASE = 64'h0000_0000_8000_0000,
    parameter int          PMEM_AW   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    ifetch_mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t             state;
    logic [63:0]        pend_addr;
    logic [15:0]        saved_half;
    logic               resp_valid_q;
    logic               resp_fault_q;
    logic [31:0]        resp_inst_q;
    logic [63:0]        resp_pc_q;

    logic               accept;
    logic               req_in_range;
    logic               req_fault;
    logic [PMEM_AW-1:0] req_widx;
    logic [PMEM_AW-1:0] pend_widx;
    logic [PMEM_AW-1:0] next_widx;
    logic               next_in_range;
    logic               upper_is_32;

    // Base check comes first, so the subtraction never wraps for in-range
    // addresses; the shifted offset must then fit in PMEM_AW word bits.
    function automatic logic in_range(input logic [63:0] a);
        logic [63:0] off;
        off = a - PMEM_BASE;
        return (a >= PMEM_BASE) && ((off >> (PMEM_AW + 2)) == 64'd0);
    endfunction

    function automatic logic [PMEM_AW-1:0] word_index(input logic [63:0] a);
        return PMEM_AW'((a - PMEM_BASE) >> 2);
    endfunction

    assign bus.req_ready  = (state == IDLE) && !bus.flush;
    assign accept         = bus.req_valid && bus.req_ready;

    assign req_in_range   = in_range(bus.req_addr);
    assign req_fault      = bus.req_addr[0] || !req_in_range;
    assign req_widx       = word_index(bus.req_addr);

    assign pend_widx      = word_index(pend_addr);
    assign next_widx      = pend_widx + {{(PMEM_AW-1){1'b0}}, 1'b1};
    // The pending address is known in range, so the following word is in
    // range unless this is the last SRAM word.
    assign next_in_range  = ~&pend_widx;

    // Upper halfword of the returned word starts a 32-bit instruction.
    assign upper_is_32    = (bus.mem_rdata[17:16] == 2'b11);

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.resp_inst  = resp_inst_q;
    assign bus.resp_pc    = resp_pc_q;

    // SRAM read port is combinational so the read issues in the same cycle
    // the decision is made; flush suppresses the second read of a straddle.
    always_comb begin
        bus.mem_en   = 1'b0;
        bus.mem_addr = '0;
        case (state)
            IDLE: begin
                if (accept && !req_fault) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = req_widx;
                end
            end
            RD0: begin
                if (!bus.flush && pend_addr[1] && upper_is_32 && next_in_range) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = next_widx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pend_addr    <= 64'd0;
            saved_half   <= 16'd0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_inst_q  <= 32'd0;
            resp_pc_q    <= 64'd0;
        end else if (bus.flush) begin
            // Redirect wins over everything; late SRAM data is simply not
            // consumed because RD0/RD1 are left.
            state        <= IDLE;
            resp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pend_addr <= bus.req_addr;
                        resp_pc_q <= bus.req_addr;
                        if (req_fault) begin
                            resp_fault_q <= 1'b1;
                            resp_inst_q  <= 32'd0;
                            resp_valid_q <= 1'b1;
                            state        <= RESP;
                        end else begin
                            state        <= RD0;
                        end
                    end
                end
                RD0: begin
                    if (!pend_addr[1]) begin
                        resp_inst_q  <= bus.mem_rdata;
                        resp_fault_q <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end else if (!upper_is_32) begin
                        resp_inst_q  <= {16'h0000, bus.mem_rdata[31:16]};
                        resp_fault_q <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end else begin
                        saved_half <= bus.mem_rdata[31:16];
                        if (!next_in_range) begin
                            resp_inst_q  <= 32'd0;
                            resp_fault_q <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state        <= RESP;
                        end else begin
                            state        <= RD1;
                        end
                    end
                end
                RD1: begin
                    resp_inst_q  <= {bus.mem_rdata[15:0], saved_half};
                    resp_fault_q <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ifetch_mem_responder.md
Name: ifetch_mem_responder

Overview:
- Responder end of the instruction-fetch interface: accepts a halfword-aligned fetch address from the fetch stage and returns a 32-bit instruction word.
- Backed by a word-wide (32-bit) synchronous-read instruction SRAM.
- Handles RVC: a 32-bit instruction at addr[1]=1 straddles two SRAM words and costs a second read. A compressed halfword costs one read.
- Sits between the fetch stage and the instruction memory. Supports flush on branch redirect.

Parameters:
- PMEM_BASE, 64'h0000_0000_8000_0000, byte address of SRAM word 0 (matches `PMEM_START).
- PMEM_AW, 16, SRAM word-address width; the SRAM holds 2^PMEM_AW words.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  64  fetch byte address.
- flush  in  1  discard the in-flight request (branch redirect).
- resp_valid  out  1  response valid.
- resp_ready  in  1  fetch stage accepts the response.
- resp_pc  out  64  address of the returned instruction.
- resp_inst  out  32  instruction; compressed instructions are zero-extended in [15:0].
- resp_fault  out  1  access fault; resp_inst is 0 when set.
- mem_en  out  1  SRAM read enable.
- mem_addr  out  PMEM_AW  SRAM word address.
- mem_rdata  in  32  SRAM data, valid the cycle after mem_en.

Behaviour:

Reset (reset=0, asynchronous): state IDLE. resp_valid, resp_fault, resp_inst, resp_pc, the saved-halfword register and the pending-address register all clear to 0.

Combinational outputs:
- req_ready = (state==IDLE) & ~flush.
- mem_en and mem_addr are combinational from state and inputs. mem_en is 0 in all cycles not listed below.

Range check: addr is in range iff addr >= PMEM_BASE and (addr-PMEM_BASE)>>2 < 2^PMEM_AW. The word index is (addr-PMEM_BASE)[PMEM_AW+1:2].

States:
- IDLE
  - On accept (req_valid & req_ready), latch the address into the pending register.
  - If addr[0]=1 or addr is out of range: go to RESP with fault=1, inst=0. No SRAM access.
  - Otherwise: mem_en=1 and mem_addr = word index of req_addr in the same cycle; go to RD0.
- RD0 (mem_rdata valid)
  - addr[1]=0: inst=mem_rdata; go to RESP.
  - addr[1]=1 and mem_rdata[17:16]!=2'b11 (compressed): inst={16'h0, mem_rdata[31:16]}; go to RESP.
  - addr[1]=1 and the low two bits are 2'b11 (32-bit instruction):
    - Save mem_rdata[31:16].
    - If word index+1 is out of range (next word outside SRAM): go to RESP with fault=1.
    - Otherwise mem_en=1, mem_addr = word index+1 (wraps within PMEM_AW bits only if in range); go to RD1.
- RD1: inst={mem_rdata[15:0], saved_half}; go to RESP.
- RESP
  - resp_valid=1. resp_pc, resp_inst and resp_fault are held stable until the handshake.
  - resp_valid & resp_ready: go to IDLE. A new request is accepted no earlier than the next cycle.

Latency, from accept edge to resp_valid:
- Fault: 1 cycle.
- Aligned, or misaligned compressed: 2 cycles.
- Misaligned 32-bit: 3 cycles.

Flush:
- Takes effect at any state and has priority over all other transitions. Next state is IDLE and resp_valid is 0 the following cycle.
- A request presented in the flush cycle is not accepted (req_ready=0).
- SRAM data returning after a flush is ignored.

Back-pressure: RESP holds indefinitely while resp_ready=0. No request is accepted meanwhile.

Reset mid-operation: immediate return to IDLE with all outputs cleared. No response is produced for the in-flight request.

Arithmetic is 64-bit unsigned. PMEM_BASE-relative subtraction never wraps because the range check precedes it.

Test Plan:
1. Reset deasserted; SRAM[0]=32'h0000_0513; req addr 0x8000_0000 -> resp_valid 2 cycles after accept, inst=0x00000513, pc=0x80000000, fault=0.
2. SRAM[1]=32'h4505_xxxx (upper half 0x4505, compressed); req 0x8000_0006 -> one SRAM read, 2-cycle latency, inst=0x00004505.
3. SRAM[1]=32'h0513_xxxx (upper half has low bits 2'b11), SRAM[2]=32'hxxxx_0000; req 0x8000_0006 -> reads of words 1 and 2, 3-cycle latency, inst=0x00000513.
4. Req 0x7FFF_FFFC, then 0x8000_0001 -> each returns fault=1, inst=0, latency 1, mem_en never asserted. Misaligned 32-bit fetch at the last SRAM word -> fault=1.
5. Hold resp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0. Then raise resp_ready -> IDLE, next request accepted the following cycle.
6. Assert flush in RD1, and separately pulse reset low during RD0 -> next cycle IDLE, resp_valid=0, no response emitted. A following request is served correctly.
